// File: rtl/usb_bulk_seq_pkg.sv
// Purpose : shared PID codes and sequencer state encoding for the bulk endpoint.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OUT_WAIT = 3'd1,
    TX_HS    = 3'd2,
    TX_DATA  = 3'd3,
    IN_WAIT  = 3'd4
  } seq_state_e;

  // DATA0 and DATA1 differ only in bit 3; bit 3 carries the toggle value.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  // DATA PID that carries the given toggle value.
  function automatic logic [3:0] data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_bulk_seq_if.sv
// Purpose : bundles the receiver report, transmitter handshake, buffer control
//           and status signals of the bulk sequencer.
// Latency : n/a.  Backpressure: tx_req is a level held until tx_done.
// Ports   : master = sequencer side, slave = receiver/transmitter/buffer side.
interface usb_bulk_seq_if;
  import usb_pkg::*;

  // configuration / receive path
  logic [6:0] dev_addr;
  logic       rx_pkt_done;
  logic [3:0] rx_pid;
  logic [6:0] rx_addr;
  logic [3:0] rx_endp;
  logic       rx_crc_ok;
  // buffer / transmit path status
  logic       buf_space_ok;
  logic       tx_data_ready;
  logic       tx_done;
  logic       clr_toggles;
  // sequencer outputs
  logic       rx_en;
  logic       tx_req;
  logic [3:0] tx_pid;
  logic       buf_commit;
  logic       buf_discard;
  logic       in_ack;
  logic       toggle_out;
  logic       toggle_in;
  logic       busy;
  logic [7:0] timeout_cnt;

  modport master (
    input  dev_addr, rx_pkt_done, rx_pid, rx_addr, rx_endp, rx_crc_ok,
           buf_space_ok, tx_data_ready, tx_done, clr_toggles,
    output rx_en, tx_req, tx_pid, buf_commit, buf_discard, in_ack,
           toggle_out, toggle_in, busy, timeout_cnt
  );

  modport slave (
    output dev_addr, rx_pkt_done, rx_pid, rx_addr, rx_endp, rx_crc_ok,
           buf_space_ok, tx_data_ready, tx_done, clr_toggles,
    input  rx_en, tx_req, tx_pid, buf_commit, buf_discard, in_ack,
           toggle_out, toggle_in, busy, timeout_cnt
  );

endinterface

// File: rtl/usb_bulk_seq_hs_timer.sv
// Purpose : clear/enable cycle counter; roll_o flags the last count (LIMIT-1).
// Latency : roll_o is combinational from the count register; count wraps on roll.
// Backpressure: none.
// Ports   : clk, rst (async, active-high), clr_i (sync clear, wins over en_i),
//           en_i (count enable), roll_o (enabled and at LIMIT-1).
module usb_hs_timer #(
  parameter int WIDTH = 7,
  parameter int LIMIT = 72
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic roll_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign roll_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = roll_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_bulk_seq.sv
// Purpose : per-transaction sequencer for one bulk endpoint: token decode,
//           commit/discard of OUT payload, ACK/NAK/DATA replies, toggles, timeouts.
// Latency : every output registered; reacts on the edge sampling rx_pkt_done/tx_done.
// Backpressure: tx_req held until tx_done; NAK when the buffer lacks space or no IN data.
// Ports   : clk, n_rst (async, active-high), bus (usb_bulk_seq_if.master).
module usb_bulk_seq
  import usb_pkg::*;
#(
  parameter logic [3:0] ENDP       = 4'd1,
  parameter int         HS_TIMEOUT = 72
) (
  input  logic                  clk,
  input  logic                  n_rst,
  usb_bulk_seq_if.master        bus
);

  localparam int TMR_W = (HS_TIMEOUT > 2) ? $clog2(HS_TIMEOUT) : 1;

  seq_state_e state_q, state_d;

  logic       rx_en_q, rx_en_d;
  logic       tx_req_q, tx_req_d;
  logic [3:0] tx_pid_q, tx_pid_d;
  logic       commit_q, commit_d;
  logic       discard_q, discard_d;
  logic       in_ack_q, in_ack_d;
  logic       tog_out_q, tog_out_d;
  logic       tog_in_q, tog_in_d;
  logic       busy_q, busy_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic token_match;
  logic data_ok;
  logic in_wait_state;
  logic tmr_roll;
  logic flip_out, flip_in, tmo_inc;

  assign token_match = bus.rx_crc_ok && (bus.rx_addr == bus.dev_addr) && (bus.rx_endp == ENDP);
  assign data_ok     = bus.rx_crc_ok && is_data_pid(bus.rx_pid);

  // Timer counts only in the two wait states and sits at zero elsewhere,
  // so it always starts from zero on entry.
  assign in_wait_state = (state_q == OUT_WAIT) || (state_q == IN_WAIT);

  usb_hs_timer #(
    .WIDTH (TMR_W),
    .LIMIT (HS_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (n_rst),
    .clr_i  (!in_wait_state),
    .en_i   (in_wait_state),
    .roll_o (tmr_roll)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q   <= IDLE;
      rx_en_q   <= 1'b1;
      tx_req_q  <= 1'b0;
      tx_pid_q  <= 4'b0000;
      commit_q  <= 1'b0;
      discard_q <= 1'b0;
      in_ack_q  <= 1'b0;
      tog_out_q <= 1'b0;
      tog_in_q  <= 1'b0;
      busy_q    <= 1'b0;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rx_en_q   <= rx_en_d;
      tx_req_q  <= tx_req_d;
      tx_pid_q  <= tx_pid_d;
      commit_q  <= commit_d;
      discard_q <= discard_d;
      in_ack_q  <= in_ack_d;
      tog_out_q <= tog_out_d;
      tog_in_q  <= tog_in_d;
      busy_q    <= busy_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Next-state logic. A packet arriving on the expiry cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.rx_pkt_done && token_match) begin
          if (bus.rx_pid == PID_OUT) begin
            state_d = OUT_WAIT;
          end else if (bus.rx_pid == PID_IN) begin
            state_d = bus.tx_data_ready ? TX_DATA : TX_HS;
          end
        end
      end
      OUT_WAIT: begin
        if (bus.rx_pkt_done) begin
          state_d = data_ok ? TX_HS : IDLE;
        end else if (tmr_roll) begin
          state_d = IDLE;
        end
      end
      TX_HS: begin
        if (bus.tx_done) state_d = IDLE;
      end
      TX_DATA: begin
        if (bus.tx_done) state_d = IN_WAIT;
      end
      IN_WAIT: begin
        if (bus.rx_pkt_done || tmr_roll) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, registered above so they appear the cycle after the
  // sampling edge together with the new state.
  always_comb begin
    commit_d  = 1'b0;
    discard_d = 1'b0;
    in_ack_d  = 1'b0;
    flip_out  = 1'b0;
    flip_in   = 1'b0;
    tmo_inc   = 1'b0;
    tx_pid_d  = tx_pid_q;

    case (state_q)
      IDLE: begin
        if (bus.rx_pkt_done && token_match && (bus.rx_pid == PID_IN)) begin
          tx_pid_d = bus.tx_data_ready ? data_pid(tog_in_q) : PID_NAK;
        end
      end
      OUT_WAIT: begin
        if (bus.rx_pkt_done) begin
          if (data_ok) begin
            if (!bus.buf_space_ok) begin
              discard_d = 1'b1;
              tx_pid_d  = PID_NAK;
            end else if (bus.rx_pid[3] == tog_out_q) begin
              commit_d  = 1'b1;
              flip_out  = 1'b1;
              tx_pid_d  = PID_ACK;
            end else begin
              // Host missed our previous ACK and resent: acknowledge, drop copy.
              discard_d = 1'b1;
              tx_pid_d  = PID_ACK;
            end
          end else begin
            discard_d = 1'b1;
          end
        end else if (tmr_roll) begin
          discard_d = 1'b1;
          tmo_inc   = 1'b1;
        end
      end
      IN_WAIT: begin
        if (bus.rx_pkt_done) begin
          if (bus.rx_pid == PID_ACK) begin
            flip_in  = 1'b1;
            in_ack_d = 1'b1;
          end
        end else if (tmr_roll) begin
          tmo_inc = 1'b1;
        end
      end
      default: ;
    endcase

    // A clear request overrides a flip in the same cycle.
    tog_out_d = bus.clr_toggles ? 1'b0 : (tog_out_q ^ flip_out);
    tog_in_d  = bus.clr_toggles ? 1'b0 : (tog_in_q ^ flip_in);

    tmo_cnt_d = (tmo_inc && (tmo_cnt_q != 8'hFF)) ? tmo_cnt_q + 8'd1 : tmo_cnt_q;

    tx_req_d = (state_d == TX_HS) || (state_d == TX_DATA);
    rx_en_d  = !tx_req_d;
    busy_d   = (state_d != IDLE);
  end

  assign bus.rx_en       = rx_en_q;
  assign bus.tx_req      = tx_req_q;
  assign bus.tx_pid      = tx_pid_q;
  assign bus.buf_commit  = commit_q;
  assign bus.buf_discard = discard_q;
  assign bus.in_ack      = in_ack_q;
  assign bus.toggle_out  = tog_out_q;
  assign bus.toggle_in   = tog_in_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_usb_bulk_seq.sv
// Purpose : randomized transaction-level bench for usb_bulk_seq against a
//           behavioural model of toggles, replies, pulses and timeout count.
// Latency : inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_usb_bulk_seq;
  import usb_pkg::*;

  localparam int         TMO  = 72;
  localparam logic [3:0] EP   = 4'd1;
  localparam logic [6:0] ADDR = 7'd5;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  usb_bulk_seq_if bus();

  usb_bulk_seq #(.ENDP(EP), .HS_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic       m_tout;
  logic       m_tin;
  int         m_tmo;
  logic [3:0] m_pid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_tout = 1'b0;
    m_tin  = 1'b0;
    m_tmo  = 0;
    m_pid  = 4'b0000;
  endtask

  task automatic tmo_bump();
    if (m_tmo < 255) m_tmo++;
  endtask

  task automatic send(input logic [3:0] pid, input logic [6:0] addr,
                      input logic [3:0] endp, input logic crc);
    bus.rx_pid      = pid;
    bus.rx_addr     = addr;
    bus.rx_endp     = endp;
    bus.rx_crc_ok   = crc;
    bus.rx_pkt_done = 1'b1;
    step();
    bus.rx_pkt_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_en"},   bus.rx_en, 1);
    chk({tag, "_tx_req"},  bus.tx_req, 0);
    chk({tag, "_tx_pid"},  bus.tx_pid, 0);
    chk({tag, "_commit"},  bus.buf_commit, 0);
    chk({tag, "_discard"}, bus.buf_discard, 0);
    chk({tag, "_in_ack"},  bus.in_ack, 0);
    chk({tag, "_tog_out"}, bus.toggle_out, 0);
    chk({tag, "_tog_in"},  bus.toggle_in, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_tmo"},     bus.timeout_cnt, 0);
  endtask

  function automatic logic [3:0] pick_other(input int n);
    logic [3:0] tbl [5];
    tbl = '{PID_OUT, PID_IN, PID_NAK, PID_DATA0, PID_DATA1};
    return tbl[n % 5];
  endfunction

  // In OUT_WAIT: deliver a good-CRC data packet and follow the reply to IDLE.
  task automatic data_resp(input logic tog, input logic space, input logic clr);
    logic       e_commit;
    logic [3:0] e_pid;
    e_commit = 1'b0;
    if (!space) begin
      e_pid = PID_NAK;
    end else begin
      e_pid = PID_ACK;
      if (tog == m_tout) begin
        e_commit = 1'b1;
        m_tout   = ~m_tout;
      end
    end
    if (clr) begin
      m_tout = 1'b0;
      m_tin  = 1'b0;
    end
    m_pid = e_pid;
    bus.buf_space_ok = space;
    bus.clr_toggles  = clr;
    send(tog ? PID_DATA1 : PID_DATA0, 7'($urandom), 4'($urandom), 1'b1);
    bus.clr_toggles  = 1'b0;
    bus.buf_space_ok = 1'($urandom_range(0, 1));
    chk("data_commit",  bus.buf_commit, e_commit);
    chk("data_discard", bus.buf_discard, !e_commit);
    chk("data_tx_pid",  bus.tx_pid, e_pid);
    chk("data_tx_req",  bus.tx_req, 1);
    chk("data_rx_en",   bus.rx_en, 0);
    chk("data_tog_out", bus.toggle_out, m_tout);
    chk("data_tog_in",  bus.toggle_in, m_tin);
    chk("data_tmo",     bus.timeout_cnt, m_tmo);
    step();
    chk("pulse_width", {bus.buf_commit, bus.buf_discard, bus.in_ack}, 0);
    if ($urandom_range(0, 1) == 1) begin
      send(pick_other($urandom), ADDR, EP, 1'b1);
      chk("tx_ignore_rx", bus.tx_req, 1);
    end
    repeat ($urandom_range(0, 5)) step();
    pulse_tx_done();
    chk("hs_done_busy",    bus.busy, 0);
    chk("hs_done_tx_req",  bus.tx_req, 0);
    chk("hs_done_rx_en",   bus.rx_en, 1);
    chk("hs_done_tog_out", bus.toggle_out, m_tout);
  endtask

  task automatic send_out();
    send(PID_OUT, ADDR, EP, 1'b1);
    chk("out_busy", bus.busy, 1);
  endtask

  // Called on cycle 0 of a wait state; leaves the bench on the expiry cycle.
  task automatic to_expiry(input string tag);
    repeat (TMO - 1) step();
    chk({tag, "_pre_busy"}, bus.busy, 1);
  endtask

  task automatic flow_out_timeout(input logic late_pkt);
    send_out();
    to_expiry("out_tmo");
    if (late_pkt) begin
      data_resp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
    end else begin
      step();
      tmo_bump();
      chk("out_tmo_discard", bus.buf_discard, 1);
      chk("out_tmo_busy",    bus.busy, 0);
      chk("out_tmo_cnt",     bus.timeout_cnt, m_tmo);
      chk("out_tmo_tx_req",  bus.tx_req, 0);
      step();
      chk("out_tmo_pulse", bus.buf_discard, 0);
    end
  endtask

  task automatic flow_out_bad();
    send_out();
    repeat ($urandom_range(0, 10)) step();
    if ($urandom_range(0, 1) == 1)
      send($urandom_range(0, 1) ? PID_DATA1 : PID_DATA0, ADDR, EP, 1'b0);
    else
      send($urandom_range(0, 1) ? PID_ACK : pick_other($urandom_range(0, 1)), ADDR, EP, 1'b1);
    chk("bad_discard", bus.buf_discard, 1);
    chk("bad_commit",  bus.buf_commit, 0);
    chk("bad_busy",    bus.busy, 0);
    chk("bad_tx_req",  bus.tx_req, 0);
    chk("bad_tog_out", bus.toggle_out, m_tout);
  endtask

  task automatic flow_in(input logic ready, input int outcome);
    bus.tx_data_ready = ready;
    send(PID_IN, ADDR, EP, 1'b1);
    bus.tx_data_ready = 1'($urandom_range(0, 1));
    m_pid = ready ? (m_tin ? PID_DATA1 : PID_DATA0) : PID_NAK;
    chk("in_tx_pid", bus.tx_pid, m_pid);
    chk("in_tx_req", bus.tx_req, 1);
    chk("in_rx_en",  bus.rx_en, 0);
    repeat ($urandom_range(0, 5)) step();
    pulse_tx_done();
    if (!ready) begin
      chk("in_nak_busy",   bus.busy, 0);
      chk("in_nak_tx_req", bus.tx_req, 0);
    end else begin
      chk("in_wait_busy",   bus.busy, 1);
      chk("in_wait_tx_req", bus.tx_req, 0);
      chk("in_wait_rx_en",  bus.rx_en, 1);
      if (outcome == 2) begin
        to_expiry("in_tmo");
        step();
        tmo_bump();
        chk("in_tmo_cnt", bus.timeout_cnt, m_tmo);
      end else begin
        repeat ($urandom_range(0, 30)) step();
        if (outcome == 0) begin
          send(PID_ACK, 7'($urandom), 4'($urandom), 1'b1);
          m_tin = ~m_tin;
          chk("in_ack_pulse", bus.in_ack, 1);
          step();
          chk("in_ack_width", bus.in_ack, 0);
        end else begin
          send(pick_other($urandom), ADDR, EP, 1'b1);
          chk("in_other_ack", bus.in_ack, 0);
        end
      end
      chk("in_end_busy",   bus.busy, 0);
      chk("in_end_tog_in", bus.toggle_in, m_tin);
    end
  endtask

  task automatic flow_mismatch();
    int k;
    k = $urandom_range(0, 3);
    bus.tx_data_ready = 1'($urandom_range(0, 1));
    case (k)
      0: send(pick_other($urandom_range(0, 1)), 7'd6, EP, 1'b1);
      1: send(pick_other($urandom_range(0, 1)), ADDR, 4'(1 + $urandom_range(1, 15)), 1'b1);
      2: send(pick_other($urandom_range(0, 1)), ADDR, EP, 1'b0);
      default: send($urandom_range(0, 1) ? PID_ACK : PID_NAK, ADDR, EP, 1'b1);
    endcase
    chk("mm_busy",    bus.busy, 0);
    chk("mm_tx_req",  bus.tx_req, 0);
    chk("mm_rx_en",   bus.rx_en, 1);
    chk("mm_pulses",  {bus.buf_commit, bus.buf_discard, bus.in_ack}, 0);
    chk("mm_tx_pid",  bus.tx_pid, m_pid);
    pulse_tx_done();
    chk("idle_txdone_busy", bus.busy, 0);
    chk("idle_txdone_req",  bus.tx_req, 0);
  endtask

  initial begin
    bus.dev_addr      = ADDR;
    bus.rx_pkt_done   = 1'b0;
    bus.rx_pid        = 4'd0;
    bus.rx_addr       = 7'd0;
    bus.rx_endp       = 4'd0;
    bus.rx_crc_ok     = 1'b0;
    bus.buf_space_ok  = 1'b1;
    bus.tx_data_ready = 1'b0;
    bus.tx_done       = 1'b0;
    bus.clr_toggles   = 1'b0;
    model_reset();

    repeat (3) step();
    check_reset("rst");
    n_rst = 1'b0;
    step();
    check_reset("post_rst");

    // Directed walk through the basic scenarios.
    send_out(); data_resp(1'b0, 1'b1, 1'b0);   // commit, ACK, toggle_out -> 1
    send_out(); data_resp(1'b0, 1'b1, 1'b0);   // retransmission: discard, ACK
    send_out(); data_resp(1'b1, 1'b0, 1'b0);   // no space: NAK
    flow_out_timeout(1'b0);
    flow_in(1'b1, 0);
    flow_in(1'b1, 2);
    flow_in(1'b0, 0);
    flow_mismatch();
    send_out(); data_resp(m_tout, 1'b1, 1'b1); // clear coincides with flip

    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          send_out();
          repeat ($urandom_range(0, 20)) step();
          data_resp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 7) == 0));
        end
        3: flow_out_bad();
        4: flow_out_timeout(1'b0);
        5: flow_out_timeout(1'b1);
        6, 7: flow_in(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
        8: flow_mismatch();
        default: begin
          bus.clr_toggles = 1'b1;
          step();
          bus.clr_toggles = 1'b0;
          m_tout = 1'b0;
          m_tin  = 1'b0;
          chk("clr_tog_out", bus.toggle_out, 0);
          chk("clr_tog_in",  bus.toggle_in, 0);
        end
      endcase
    end

    // Asynchronous reset while waiting for OUT data.
    send_out();
    repeat (3) step();
    #2 n_rst = 1'b1;
    #1;
    check_reset("arst");
    model_reset();
    step();
    n_rst = 1'b0;
    step();
    chk("arst_release_busy", bus.busy, 0);

    // Timeout counter saturation.
    for (int i = 0; i < 258; i++) begin
      send(PID_OUT, ADDR, EP, 1'b1);
      repeat (TMO) step();
      tmo_bump();
      chk("sat_tmo_cnt", bus.timeout_cnt, m_tmo);
    end
    chk("sat_final", bus.timeout_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
